// File: rtl/fetch_npc_pkg.sv
// Shared fetch/decode constants: opcode and funct encodings, reset PC, nop.
package fetch_npc_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;

   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [5:0] FUNCT_JALR = 6'b001001;

   // Control-transfer class of the instruction sitting in ID
   typedef enum logic [2:0] {
      CF_SEQ  = 3'd0,
      CF_BEQ  = 3'd1,
      CF_BNE  = 3'd2,
      CF_JUMP = 3'd3,
      CF_JREG = 3'd4
   } cf_kind_e;

   // Classify an instruction word by its opcode/funct fields
   function automatic cf_kind_e decode_cf(input logic [XLEN-1:0] instr);
      cf_kind_e kind;
      kind = CF_SEQ;
      case (instr[31:26])
         OP_BEQ:         kind = CF_BEQ;
         OP_BNE:         kind = CF_BNE;
         OP_J, OP_JAL:   kind = CF_JUMP;
         OP_SPECIAL: begin
            if (instr[5:0] == FUNCT_JR || instr[5:0] == FUNCT_JALR)
               kind = CF_JREG;
         end
         default:        kind = CF_SEQ;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/fetch_npc_npc_calc.sv
// Combinational next-PC selection for the branch/jump resolved in ID.
module npc_calc
   import fetch_npc_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] id_pc,
   input  logic [31:0] id_instr,
   input  logic        equal,
   input  logic [31:0] rs_val,
   output logic [31:0] next_pc
);

   cf_kind_e    kind;
   logic [31:0] seq_pc;
   logic [31:0] br_target;
   logic [31:0] j_target;

   assign kind      = decode_cf(id_instr);
   assign seq_pc    = pc + 32'd4;
   // Branch target relative to the delay-slot address; wraps modulo 2^32
   assign br_target = id_pc + 32'd4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
   assign j_target  = {id_pc[31:28], id_instr[25:0], 2'b00};

   // Priority select of the fetch address for the next edge
   always_comb begin
      next_pc = seq_pc;
      case (kind)
         CF_BEQ:  if (equal)  next_pc = br_target;
         CF_BNE:  if (!equal) next_pc = br_target;
         CF_JUMP: next_pc = j_target;
         CF_JREG: next_pc = rs_val;
         default: next_pc = seq_pc;
      endcase
   end

endmodule

// File: rtl/fetch_npc.sv
// Fetch stage: PC register, IF/ID pipeline register and next-PC selection
// with a single architectural delay slot.
module fetch_npc
   import fetch_npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] imem_instr,
   input  logic        equal,
   input  logic [31:0] rs_val,
   output logic [31:0] pc,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8
);

   logic [31:0] next_pc;

   npc_calc u_npc_calc (
      .pc       (pc),
      .id_pc    (id_pc),
      .id_instr (id_instr),
      .equal    (equal),
      .rs_val   (rs_val),
      .next_pc  (next_pc)
   );

   // PC and IF/ID update; stalled cycles hold everything and drop any redirect
   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         id_instr <= NOP_INSTR;
         id_pc    <= 32'h0000_0000;
      end else if (!stall) begin
         pc       <= next_pc;
         id_instr <= imem_instr;
         id_pc    <= pc;
      end
   end

   // Link address for jal/jalr
   assign id_pc8 = id_pc + 32'd8;

endmodule

// File: tb/tb_fetch_npc.sv
// Directed scoreboard bench for fetch_npc.
module tb_fetch_npc;

   logic        clk;
   logic        reset;
   logic        stall;
   logic [31:0] imem_instr;
   logic        equal;
   logic [31:0] rs_val;
   logic [31:0] pc;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc8;

   int tests_run;
   int tests_failed;

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [31:0] id_instr;
      logic [31:0] id_pc;
   } exp_t;

   exp_t sb[$];
   int   step_no;

   localparam logic [31:0] NOP      = 32'h0000_0000;
   localparam logic [31:0] BEQ_M1   = 32'h1000_FFFF;
   localparam logic [31:0] BEQ_M2   = 32'h1000_FFFE;
   localparam logic [31:0] BNE_P3   = 32'h1400_0003;
   localparam logic [31:0] BNE_P16  = 32'h1400_0010;
   localparam logic [31:0] J_C10    = 32'h0800_0C10;
   localparam logic [31:0] JAL_C10  = 32'h0C00_0C10;
   localparam logic [31:0] JR_RA    = 32'h03E0_0008;
   localparam logic [31:0] JALR_I   = 32'h0000_0009;
   localparam logic [31:0] DS       = 32'h2408_0001;

   fetch_npc #(.RESET_PC(32'h0000_3000)) dut (
      .clk        (clk),
      .reset      (reset),
      .stall      (stall),
      .imem_instr (imem_instr),
      .equal      (equal),
      .rs_val     (rs_val),
      .pc         (pc),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc8     (id_pc8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input int tag, input string what, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("FAIL step %0d %s: got %08h expected %08h", tag, what, act, req);
      end
   endtask

   // Drive one cycle of inputs and queue the state expected after the next edge
   task automatic step(input logic r, input logic s, input logic [31:0] instr,
                       input logic eq, input logic [31:0] rs,
                       input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_idpc);
      exp_t e;
      @(negedge clk);
      reset      = r;
      stall      = s;
      imem_instr = instr;
      equal      = eq;
      rs_val     = rs;
      step_no++;
      e.tag      = step_no;
      e.pc       = e_pc;
      e.id_instr = e_instr;
      e.id_pc    = e_idpc;
      sb.push_back(e);
   endtask

   // Monitor: compare DUT state just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, "pc",       pc,       e.pc);
            check(e.tag, "id_instr", id_instr, e.id_instr);
            check(e.tag, "id_pc",    id_pc,    e.id_pc);
            check(e.tag, "id_pc8",   id_pc8,   e.id_pc + 32'd8);
         end
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      step_no      = 0;
      reset        = 1'b1;
      stall        = 1'b0;
      imem_instr   = NOP;
      equal        = 1'b0;
      rs_val       = 32'h0;

      //    rst  stl instr    eq    rs_val        pc            id_instr  id_pc
      // sequential fetch after reset
      step(1'b1, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3000, NOP,     32'h0000_0000);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3004, NOP,     32'h0000_3000);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3008, NOP,     32'h0000_3004);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_300C, NOP,     32'h0000_3008);
      // beq -1 at 0x3004: taken, then not taken; delay slot always enters ID
      step(1'b1, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3000, NOP,     32'h0000_0000);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3004, NOP,     32'h0000_3000);
      step(1'b0, 1'b0, BEQ_M1,  1'b0, 32'h0,        32'h0000_3008, BEQ_M1,  32'h0000_3004);
      step(1'b0, 1'b0, DS,      1'b1, 32'h0,        32'h0000_3004, DS,      32'h0000_3008);
      step(1'b0, 1'b0, BEQ_M1,  1'b0, 32'h0,        32'h0000_3008, BEQ_M1,  32'h0000_3004);
      step(1'b0, 1'b0, DS,      1'b0, 32'h0,        32'h0000_300C, DS,      32'h0000_3008);
      // j / jal absolute targets
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3010, NOP,     32'h0000_300C);
      step(1'b0, 1'b0, J_C10,   1'b0, 32'h0,        32'h0000_3014, J_C10,   32'h0000_3010);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3040, NOP,     32'h0000_3014);
      step(1'b0, 1'b0, JAL_C10, 1'b0, 32'h0,        32'h0000_3044, JAL_C10, 32'h0000_3040);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3040, NOP,     32'h0000_3044);
      // jr held over two stalls while rs_val becomes valid
      step(1'b0, 1'b0, JR_RA,   1'b0, 32'h0,        32'h0000_3044, JR_RA,   32'h0000_3040);
      step(1'b0, 1'b1, DS,      1'b0, 32'h0,        32'h0000_3044, JR_RA,   32'h0000_3040);
      step(1'b0, 1'b1, DS,      1'b0, 32'h0000_3100, 32'h0000_3044, JR_RA,  32'h0000_3040);
      step(1'b0, 1'b0, DS,      1'b0, 32'h0000_3100, 32'h0000_3100, DS,     32'h0000_3044);
      // jalr to top of address space, then sequential wrap to 0
      step(1'b0, 1'b0, JALR_I,  1'b0, 32'h0,        32'h0000_3104, JALR_I,  32'h0000_3100);
      step(1'b0, 1'b0, NOP,     1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,    32'h0000_3104);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_0000, NOP,     32'hFFFF_FFFC);
      // negative branch from address 0 wraps below zero
      step(1'b0, 1'b0, BEQ_M2,  1'b0, 32'h0,        32'h0000_0004, BEQ_M2,  32'h0000_0000);
      step(1'b0, 1'b0, NOP,     1'b1, 32'h0,        32'hFFFF_FFFC, NOP,     32'h0000_0004);
      // unaligned jr target passes through untouched
      step(1'b0, 1'b0, JR_RA,   1'b0, 32'h0,        32'h0000_0000, JR_RA,   32'hFFFF_FFFC);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0000_3101, 32'h0000_3101, NOP,    32'h0000_0000);
      // taken bne discarded by reset (reset also beats stall)
      step(1'b0, 1'b0, BNE_P16, 1'b0, 32'h0,        32'h0000_3105, BNE_P16, 32'h0000_3101);
      step(1'b1, 1'b1, DS,      1'b0, 32'h0,        32'h0000_3000, NOP,     32'h0000_0000);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3004, NOP,     32'h0000_3000);
      step(1'b0, 1'b1, DS,      1'b0, 32'h0,        32'h0000_3004, NOP,     32'h0000_3000);
      // bne taken (equal=0) then not taken (equal=1)
      step(1'b0, 1'b0, BNE_P3,  1'b0, 32'h0,        32'h0000_3008, BNE_P3,  32'h0000_3004);
      step(1'b0, 1'b0, NOP,     1'b0, 32'h0,        32'h0000_3014, NOP,     32'h0000_3008);
      step(1'b0, 1'b0, BNE_P3,  1'b0, 32'h0,        32'h0000_3018, BNE_P3,  32'h0000_3014);
      step(1'b0, 1'b0, NOP,     1'b1, 32'h0,        32'h0000_301C, NOP,     32'h0000_3018);

      // let the monitor drain, bounded
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (sb.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/fetch_npc.md
FETCH_NPC -- requirements
Module: fetch_npc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: PC value loaded at reset.
REQ-002 Clock and reset are fixed: one clock, `clk`; reset is `reset`, synchronous and active-high.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 stall  in  1  from hazard unit; 1 freezes PC and IF/ID register.
REQ-006 imem_instr  in  32  instruction read from IM at address pc.
REQ-007 equal  in  1  from ID-stage comparator; 1 when forwarded rs value equals forwarded rt value.
REQ-008 rs_val  in  32  forwarded rs value in ID; jump target for jr/jalr.
REQ-009 pc  out  32  current fetch address to IM.
REQ-010 id_instr  out  32  IF/ID instruction register.
REQ-011 id_pc  out  32  IF/ID PC register.
REQ-012 id_pc8  out  32  id_pc+8; link address for jal/jalr.

Function
REQ-013 Decoding of id_instr SHALL use these encodings: beq op=000100; bne op=000101; j op=000010; jal op=000011; jr op=000000 with funct=001000; jalr op=000000 with funct=001001.
REQ-014 Next-PC priority when stall=0:
- beq with equal=1 -> id_pc+4+(sext(imm16)<<2)
- bne with equal=0 -> same branch target
- j/jal -> {id_pc[31:28], instr_index, 2'b00}
- jr/jalr -> rs_val
- otherwise -> pc+4
REQ-015 Branch/jump resolution SHALL occur in ID with one architectural delay slot: the instruction in IF when the branch is in ID is always latched into IF/ID and executed, never flushed.
REQ-016 When stall=0, each rising edge SHALL load: pc <= next PC; id_instr <= imem_instr; id_pc <= pc.
REQ-017 When stall=1, pc, id_instr and id_pc SHALL hold. A redirect decided during a stalled cycle SHALL NOT be applied; it is re-evaluated with updated forwarded equal/rs_val on the first unstalled cycle.
REQ-018 Latency: a taken control transfer in ID SHALL appear on pc exactly one unstalled edge later.
REQ-019 All address arithmetic is 32-bit modulo 2^32. 0xFFFF_FFFC+4 wraps to 0. A negative branch offset below 0 wraps.
REQ-020 jr targets SHALL be used unmodified, including nonzero bits [1:0]; alignment checking belongs downstream.
REQ-021 id_pc8 SHALL be combinational from id_pc.
REQ-022 pc SHALL be driven directly from the register, with no combinational path from inputs.

Reset
REQ-023 On reset=1 at a rising edge: pc <= RESET_PC; id_instr <= 32'h0000_0000 (nop); id_pc <= 32'h0000_0000.
REQ-024 Reset SHALL take priority over stall and over any pending redirect.
REQ-025 Reset asserted mid-branch SHALL discard the branch; the first post-reset fetch is RESET_PC, followed by RESET_PC+4.

Structure
REQ-026 The opcode/funct constants, RESET_PC default and the nop encoding SHALL live in the shared package used by decode/control.
REQ-027 One sub-module, npc_calc, SHALL be purely combinational. It takes pc, id_pc, id_instr, equal and rs_val, and produces next_pc. The PC and IF/ID registers stay in fetch_npc.

Verification
REQ-028 Reset, then 3 edges with stall=0 and nop in ID -> pc = 0x3000, 0x3004, 0x3008, 0x300C; id_pc trails pc by one edge.
REQ-029 id_pc=0x3004, beq imm=0xFFFF, equal=1 -> next pc=0x3004. With equal=0 -> pc+4. The delay-slot instruction at 0x3008 appears in id_instr.
REQ-030 j instr_index=0x0000C10 with id_pc=0x3010 -> pc=0x0000_3040. jal with id_pc=0x3010 -> id_pc8=0x3018.
REQ-031 jr with rs_val=0x0000_3100, stall=1 for 2 cycles during which rs_val changes from 0 to 0x3100 -> pc holds for 2 cycles, then becomes 0x3100.
REQ-032 pc=0xFFFF_FFFC with no branch -> pc=0x0000_0000.
REQ-033 Taken bne in ID with reset=1 on the same edge -> pc=RESET_PC and id_instr=0.
